// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and helpers for the register file controller
package regfile_pkg;

  localparam int REGFILE_WIDTH_DEFAULT = 8;
  localparam int REGFILE_DEPTH_DEFAULT = 4;

  typedef enum logic {
    REGFILE_IDLE  = 1'b0,
    REGFILE_CLEAR = 1'b1
  } regfile_state_e;

  // Index width needed to address `value` entries (minimum 1 bit).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - hardware clear sequencer: walks every register index once and flags busy
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = REGFILE_DEPTH_DEFAULT,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  regfile_state_e state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           busy_q, busy_d;

  // Next-state: a clear request is only honoured from IDLE, so requests during a sweep are ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    case (state_q)
      REGFILE_IDLE: begin
        if (clear_req) begin
          state_d = REGFILE_CLEAR;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      REGFILE_CLEAR: begin
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = REGFILE_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = REGFILE_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, sweep index and registered busy flag; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= REGFILE_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign clr_we  = (state_q == REGFILE_CLEAR);
  assign clr_idx = idx_q;

endmodule

// File: rtl/register_file_ctrl.sv
// rtl/register_file_ctrl.sv - DEPTH x WIDTH register file, two registered read ports, clear sequencer; optional REGFILE_WRITE_BYPASS_EN
module register_file_ctrl
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH_DEFAULT,
  parameter int DEPTH = REGFILE_DEPTH_DEFAULT,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             save,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             clear_req,
  output logic             busy
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rd_a_q, rd_a_d;
  logic [WIDTH-1:0] rd_b_q, rd_b_d;
  logic             clr_we;
  logic [AW-1:0]    clr_idx;
  logic             wr_accept;

  regfile_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  // A write lands only in IDLE, loses to a same-edge clear request, and must target an existing register.
  assign wr_accept = !clr_we && save && !clear_req && (32'(wr_addr) < DEPTH);

  // Storage update: the clear sweep owns the array while it runs.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (clr_we && (32'(clr_idx) == i)) begin
        regs_d[i] = '0;
      end else if (wr_accept && (32'(wr_addr) == i)) begin
        regs_d[i] = alu_out;
      end
    end
  end

  // Read muxes: out-of-range indices read as zero; same-edge writes forward only when bypass is built in.
  always_comb begin
    rd_a_d = '0;
    rd_b_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(rd_addr_a) == i) rd_a_d = regs_q[i];
      if (32'(rd_addr_b) == i) rd_b_d = regs_q[i];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_accept && (rd_addr_a == wr_addr)) rd_a_d = alu_out;
    if (wr_accept && (rd_addr_b == wr_addr)) rd_b_d = alu_out;
`endif
  end

  // Array and read-data registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign data_out_a = rd_a_q;
  assign data_out_b = rd_b_q;

endmodule

// File: tb/tb_register_file_ctrl.sv
// tb/tb_register_file_ctrl.sv - scoreboard bench for register_file_ctrl (default and 5x16 instances)
module tb_register_file_ctrl;

  typedef struct {
    logic        save;
    int          wa;
    logic [15:0] d;
    int          ra;
    int          rb;
    logic        clr;
  } stim_t;

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       s0_save = 0, s0_clr = 0;
  logic [1:0] s0_wa = 0, s0_ra = 0, s0_rb = 0;
  logic [7:0] s0_d = 0;
  logic [7:0] o0_a, o0_b;
  logic       o0_busy;

  logic        s1_save = 0, s1_clr = 0;
  logic [2:0]  s1_wa = 0, s1_ra = 0, s1_rb = 0;
  logic [15:0] s1_d = 0;
  logic [15:0] o1_a, o1_b;
  logic        o1_busy;

  int n_total = 0;
  int n_pass  = 0;

  exp_t        exp_q[$];
  logic [15:0] mem [2][8];
  int          clr_left [2];

  always #5 clk = ~clk;

  register_file_ctrl u_dut0 (
    .clk(clk), .reset(reset), .save(s0_save), .wr_addr(s0_wa), .alu_out(s0_d),
    .rd_addr_a(s0_ra), .rd_addr_b(s0_rb), .data_out_a(o0_a), .data_out_b(o0_b),
    .clear_req(s0_clr), .busy(o0_busy)
  );

  register_file_ctrl #(.WIDTH(16), .DEPTH(5)) u_dut1 (
    .clk(clk), .reset(reset), .save(s1_save), .wr_addr(s1_wa), .alu_out(s1_d),
    .rd_addr_a(s1_ra), .rd_addr_b(s1_rb), .data_out_a(o1_a), .data_out_b(o1_b),
    .clear_req(s1_clr), .busy(o1_busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  function automatic stim_t st(input bit save, input int wa, input int d,
                               input int ra, input int rb, input bit clr);
    stim_t s;
    s.save = save; s.wa = wa; s.d = 16'(d); s.ra = ra; s.rb = rb; s.clr = clr;
    return s;
  endfunction

  // Reference: registers as an array, a clear as "DEPTH more cycles, zeroing index DEPTH-left".
  task automatic model(input int i, input stim_t s);
    int dep, asz, wa, ra, rb;
    logic [15:0] m, ea, eb;
    bit acc;
    exp_t e;
    dep = (i == 0) ? 4 : 5;
    asz = (i == 0) ? 4 : 8;
    m   = (i == 0) ? 16'h00FF : 16'hFFFF;
    wa = s.wa % asz; ra = s.ra % asz; rb = s.rb % asz;
    acc = (clr_left[i] == 0) && !s.clr && s.save && (wa < dep);
    ea = (ra < dep) ? mem[i][ra] : 16'h0;
    eb = (rb < dep) ? mem[i][rb] : 16'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (acc && ra == wa) ea = s.d & m;
    if (acc && rb == wa) eb = s.d & m;
`endif
    if (clr_left[i] > 0) begin
      mem[i][dep - clr_left[i]] = 16'h0;
      clr_left[i]--;
    end else if (s.clr) begin
      clr_left[i] = dep;
    end else if (acc) begin
      mem[i][wa] = s.d & m;
    end
    e.inst = i; e.a = ea; e.b = eb; e.busy = (clr_left[i] > 0);
    exp_q.push_back(e);
  endtask

  task automatic tick(input stim_t a, input stim_t b);
    @(negedge clk);
    s0_save = a.save; s0_wa = 2'(a.wa); s0_d = 8'(a.d); s0_ra = 2'(a.ra); s0_rb = 2'(a.rb); s0_clr = a.clr;
    s1_save = b.save; s1_wa = 3'(b.wa); s1_d = b.d;     s1_ra = 3'(b.ra); s1_rb = 3'(b.rb); s1_clr = b.clr;
    model(0, a);
    model(1, b);
  endtask

  // Reset is asserted between edges; its effect on the outputs must be immediate.
  task automatic apply_reset();
    @(negedge clk);
    #1;
    s0_save = 0; s0_clr = 0; s1_save = 0; s1_clr = 0;
    reset = 1'b1;
    #1;
    check("rst_busy0", {15'h0, o0_busy}, 16'h0);
    check("rst_busy1", {15'h0, o1_busy}, 16'h0);
    check("rst_a0", {8'h0, o0_a}, 16'h0);
    check("rst_b0", {8'h0, o0_b}, 16'h0);
    check("rst_a1", o1_a, 16'h0);
    check("rst_b1", o1_b, 16'h0);
    for (int i = 0; i < 2; i++) begin
      clr_left[i] = 0;
      for (int j = 0; j < 8; j++) mem[i][j] = 16'h0;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: read data and busy are presented every cycle, so every edge retires the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.inst == 0) begin
          check("i0_data_a", {8'h0, o0_a}, e.a);
          check("i0_data_b", {8'h0, o0_b}, e.b);
          check("i0_busy", {15'h0, o0_busy}, {15'h0, e.busy});
        end else begin
          check("i1_data_a", o1_a, e.a);
          check("i1_data_b", o1_b, e.b);
          check("i1_busy", {15'h0, o1_busy}, {15'h0, e.busy});
        end
      end
    end
  end

  initial begin
    stim_t idle;
    idle = st(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      clr_left[i] = 0;
      for (int j = 0; j < 8; j++) mem[i][j] = 16'h0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    apply_reset();

    // Reset contents on both ports
    for (int a = 0; a < 5; a++) tick(st(0, 0, 0, a, 3 - a, 0), st(0, 0, 0, a, 4 - a, 0));

    // Write-to-read latency
    tick(st(1, 2, 'hA5, 0, 3, 0), idle);
    tick(st(0, 0, 0, 2, 3, 0), idle);
    tick(st(0, 0, 0, 2, 3, 0), idle);

    // Read during write
    tick(st(1, 1, 'h11, 0, 0, 0), idle);
    tick(st(1, 1, 'h22, 1, 1, 0), idle);
    tick(st(0, 0, 0, 1, 1, 0), idle);

    // Clear sweep with a dropped write in the middle
    for (int r = 0; r < 4; r++) tick(st(1, r, r + 1, r, 3 - r, 0), idle);
    tick(st(0, 0, 0, 0, 3, 1), idle);
    tick(st(1, 0, 'hFF, 0, 3, 0), idle);
    tick(st(0, 0, 0, 0, 1, 1), idle);
    for (int r = 0; r < 4; r++) tick(st(0, 0, 0, r, 3 - r, 0), idle);
    for (int r = 0; r < 4; r++) tick(st(0, 0, 0, r, r, 0), idle);

    // Clear beats a same-edge write
    tick(st(1, 3, 'h44, 3, 3, 0), idle);
    tick(st(1, 3, 'h77, 3, 3, 1), idle);
    for (int r = 0; r < 6; r++) tick(st(0, 0, 0, 3, r % 4, 0), idle);

    // Reset in the middle of a sweep, then an immediate write
    tick(st(1, 1, 'h5A, 1, 1, 0), idle);
    tick(st(0, 0, 0, 1, 1, 1), idle);
    tick(st(0, 0, 0, 1, 0, 0), idle);
    tick(st(0, 0, 0, 1, 0, 0), idle);
    apply_reset();
    tick(st(1, 0, 'h3C, 0, 1, 0), idle);
    tick(st(0, 0, 0, 0, 1, 0), idle);

    // 5 x 16 instance: top register, out-of-range index, 5-cycle sweep
    tick(idle, st(1, 4, 'hBEEF, 4, 6, 0));
    tick(idle, st(1, 6, 'h1234, 4, 6, 0));
    tick(idle, st(0, 0, 0, 4, 6, 0));
    tick(idle, st(0, 0, 0, 6, 4, 1));
    for (int r = 0; r < 7; r++) tick(idle, st(0, 0, 0, 4, r, 0));

    // Randomised traffic on both instances
    for (int n = 0; n < 400; n++) begin
      stim_t a, b;
      a = st($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
             $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
      b = st($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 65535),
             $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 15) == 0));
      if (n % 40 == 17) begin
        a.wa = b.wa % 4; a.ra = a.wa; b.ra = b.wa;
      end
      tick(a, b);
      if ($urandom_range(0, 99) == 0) apply_reset();
    end
    tick(idle, idle);
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/register_file_ctrl.md
Name: register_file_ctrl

Overview:
- Parametrised successor to the single 8-bit CPU working register.
- Holds DEPTH registers of WIDTH bits, written from the ALU result bus, with two independently addressed registered read ports feeding the ALU operand muxes.
- Adds a clocked write path, a hardware clear sequencer with a busy flag, and optional write-to-read forwarding.

Parameters:
- WIDTH, 8, data width of each register and of the ALU result bus
- DEPTH, 4, number of registers; any value >= 2, not required to be a power of two

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- save  input  1  write enable; writes alu_out to register wr_addr
- wr_addr  input  AW  write register index; AW = clog2(DEPTH)
- alu_out  input  WIDTH  write data from ALU
- rd_addr_a  input  AW  read port A index
- rd_addr_b  input  AW  read port B index
- data_out_a  output  WIDTH  registered read data, port A
- data_out_b  output  WIDTH  registered read data, port B
- clear_req  input  1  single-cycle request to zero all registers
- busy  output  1  high while the clear sequence runs

Behaviour:
- Reset (asynchronous, active-high):
  - all registers, data_out_a, data_out_b and the clear index go to 0.
  - busy goes to 0 and state goes to IDLE.
  - Takes effect immediately, including mid-clear.
- Write:
  - On a rising edge with state IDLE, save=1, clear_req=0 and wr_addr < DEPTH: reg[wr_addr] <= alu_out.
  - wr_addr >= DEPTH: write silently dropped.
- Read:
  - Every rising edge: data_out_a <= reg[rd_addr_a] and data_out_b <= reg[rd_addr_b].
  - Latency is 1 cycle from address to data.
  - Out-of-range address returns 0.
  - Both ports may address the same register.
- Read-during-write, same address, same edge: returns the old contents. This is changed by the optional feature.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR: clear_req=1 sampled in IDLE; the clear index is loaded with 0.
  - In CLEAR, each edge zeroes reg[index] and increments index.
  - CLEAR -> IDLE: on the edge that zeroes reg[DEPTH-1].
  - busy is registered and equals (state==CLEAR). It is high for exactly DEPTH cycles, starting the cycle after clear_req is sampled.
  - Reads during CLEAR continue and return current contents, so already-cleared registers read 0.
- Boundary conditions:
  - save during CLEAR: dropped, not queued. Software must poll busy.
  - clear_req during CLEAR: ignored; no restart.
  - clear_req and save on the same IDLE edge: clear wins and the write is dropped.
  - clear_req held high across several cycles: one sequence per IDLE entry. If still high on return to IDLE, a new sequence starts.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when a write is accepted on an edge and rd_addr_x equals wr_addr, data_out_x takes alu_out (new data). This applies per port. There is no bypass for writes dropped during CLEAR or by clear priority.
- Undefined: old contents are returned, as described under Read-during-write. No extra comparators are synthesised.

Decomposition:
- Shared package regfile_pkg:
  - state encoding constants REGFILE_IDLE=1'b0 and REGFILE_CLEAR=1'b1
  - default WIDTH/DEPTH constants
  - clog2 function used to derive AW.
- One natural sub-module: regfile_clear_seq.
  - Contains the FSM, clear index counter and busy flag.
  - Outputs clr_we and clr_idx to the storage array in the top level.

Test Plan:
- Reset then read all: assert reset mid-cycle, release; read addr 0..3 on both ports -> data_out_a/b = 8'h00, busy=0 immediately on reset assertion.
- Write/read latency: save=1, wr_addr=2, alu_out=8'hA5 at edge N; rd_addr_a=2 at edge N+1 -> data_out_a=8'hA5 after edge N+1. Port B reading reg 3 stays 8'h00.
- Read-during-write: reg1=8'h11, then write 8'h22 to reg1 with rd_addr_a=1 on the same edge -> data_out_a=8'h11 without the macro, 8'h22 with REGFILE_WRITE_BYPASS_EN. Next edge -> 8'h22 in both builds.
- Clear sequence:
  - Setup: load regs with 8'h01..8'h04, then pulse clear_req.
  - Expected: busy high exactly 4 cycles.
  - Expected: save of 8'hFF to reg0 during busy is dropped.
  - Expected: all regs read 8'h00 afterwards.
- Priority and reset mid-clear:
  - clear_req and save (reg3, 8'h77) on the same edge -> reg3 ends 8'h00.
  - Reset asserted at clear cycle 2 -> busy=0 at once; a write 1 cycle after release is accepted.
- DEPTH=5, WIDTH=16 build: write 16'hBEEF to reg4, read back -> 16'hBEEF. wr_addr=6 write ignored, rd_addr=6 -> 0. Clear busy for 5 cycles.
